otter_pc_redirect_ctrl: RTL and testbench
=========================================

OTTER_PC_REDIRECT_CTRL -- requirements
Module: otter_pc_redirect_ctrl

Interface
REQ-001 SHALL provide ports: CLK input 1 system clock; RST_N input 1 reset, asynchronous, active-low.
REQ-002 SHALL provide EX_VALID input 1: EX-stage instruction valid (not a bubble).
REQ-003 SHALL provide EX_PC_SRC input 3: PC-source code resolved in EX (000 seq, 001 JALR, 010 branch, 011 JAL, 101 mret); 100 is never driven here.
REQ-004 SHALL provide STALL input 1: hazard-unit stall, PC and IF/ID frozen.
REQ-005 SHALL provide INTR input 1: external interrupt request, level; MIE input 1: CSR global interrupt enable.
REQ-006 SHALL provide PC_SEL output 3: PC mux select; PC_WRITE output 1; FLUSH_IF_ID output 1; FLUSH_ID_EX output 1.
REQ-007 SHALL provide INT_TAKEN output 1: one-cycle strobe to CSR file (save mepc, clear MIE).
REQ-008 SHALL provide IN_ISR output 1: handler active, high from INT_TAKEN until mret redirect.

Function
REQ-009 SHALL implement FSM states RUN, SHADOW, INT_WAIT, INT_ENTER, registered on CLK.
REQ-010 Redirect = EX_VALID and EX_PC_SRC not 000 and not STALL, evaluated only in RUN or INT_WAIT.
REQ-011 On redirect SHALL drive PC_SEL=EX_PC_SRC, PC_WRITE=1, FLUSH_IF_ID=1, FLUSH_ID_EX=1 in the same cycle (zero latency) and SHALL go to SHADOW.
REQ-012 SHADOW SHALL last exactly one cycle, ignore EX_VALID/EX_PC_SRC, drive PC_SEL=000, PC_WRITE=not STALL, no flush; then RUN, or INT_WAIT if an interrupt is pending.
REQ-013 Pending flag SHALL set when INTR and MIE and not IN_ISR; SHALL clear on entry to INT_ENTER.
REQ-014 In RUN with pending and no redirect SHALL go to INT_WAIT; redirect in the same cycle SHALL win (go to SHADOW, pending kept).
REQ-015 INT_WAIT SHALL go to INT_ENTER on first cycle with STALL=0 and no redirect.
REQ-016 INT_ENTER SHALL drive PC_SEL=100, PC_WRITE=1, both flushes, INT_TAKEN=1 for exactly one cycle, set IN_ISR, then go to SHADOW.
REQ-017 IN_ISR SHALL clear on a redirect with EX_PC_SRC=101; nested interrupts SHALL NOT be taken while IN_ISR=1.
REQ-018 In RUN with no redirect: PC_SEL=000, PC_WRITE=not STALL, flushes 0.
REQ-019 INTR deasserting while in INT_WAIT SHALL NOT cancel entry (pending latched).

Reset
REQ-020 RST_N low SHALL immediately force state RUN, pending=0, IN_ISR=0 and all outputs 0 (PC_SEL=000, PC_WRITE=0) regardless of other inputs, including mid-INT_WAIT or mid-SHADOW.
REQ-021 First rising CLK after RST_N release SHALL behave as RUN.

Configuration
REQ-022 Macro OTTER_REDIRECT_STATS_EN defined: SHALL add outputs REDIR_CNT 16 and INT_CNT 16, saturating counters incremented on each redirect / INT_TAKEN, reset to 0.
REQ-023 Macro undefined: counters and ports SHALL be absent; all other behaviour identical.

Structure
REQ-024 Shared package otter_pkg SHALL hold the FSM state enum, PC_SEL code constants (PCSEL_SEQ 000, JALR 001, BRANCH 010, JAL 011, INTR 100, MRET 101) and existing opcode_t.
REQ-025 Single module; counter may be sub-module otter_sat_counter (parameter WIDTH=16).

Verification
REQ-026 EX_VALID=1, EX_PC_SRC=010, STALL=0 -> same cycle PC_SEL=010, both flushes=1; next cycle SHADOW, PC_SEL=000 even if EX_PC_SRC=011.
REQ-027 INTR=1, MIE=1, idle pipeline -> INT_WAIT then INT_ENTER: PC_SEL=100, INT_TAKEN=1 one cycle, IN_ISR=1.
REQ-028 INTR and JAL redirect same cycle -> PC_SEL=011 first, SHADOW, INT_WAIT, then INT_TAKEN 3 cycles after redirect.
REQ-029 IN_ISR=1, INTR=1 held -> no INT_TAKEN; EX_PC_SRC=101 redirect -> PC_SEL=101, IN_ISR=0, next interrupt accepted.
REQ-030 STALL=1 for 4 cycles in INT_WAIT -> PC_WRITE=0, no INT_TAKEN until STALL drops; RST_N pulse mid-INT_WAIT -> outputs 0, no INT_TAKEN after release with INTR=0.
REQ-031 With OTTER_REDIRECT_STATS_EN, 65540 redirects -> REDIR_CNT=16'hFFFF (saturated).

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types for the Otter pipeline: PC-control FSM states, PC mux select codes, base opcodes.
package otter_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SHADOW    = 2'd1,
    ST_INT_WAIT  = 2'd2,
    ST_INT_ENTER = 2'd3
  } pc_state_t;

  localparam logic [2:0] PCSEL_SEQ    = 3'b000;
  localparam logic [2:0] PCSEL_JALR   = 3'b001;
  localparam logic [2:0] PCSEL_BRANCH = 3'b010;
  localparam logic [2:0] PCSEL_JAL    = 3'b011;
  localparam logic [2:0] PCSEL_INTR   = 3'b100;
  localparam logic [2:0] PCSEL_MRET   = 3'b101;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating event counter: counts inc_i pulses, holds at all-ones.
module otter_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/otter_pc_redirect_ctrl.sv
// PC redirect / interrupt-entry controller: zero-latency EX redirects, one shadow cycle after each PC change.
// OTTER_REDIRECT_STATS_EN adds saturating REDIR_CNT / INT_CNT outputs.
module otter_pc_redirect_ctrl
  import otter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EX_VALID,
  input  logic [2:0] EX_PC_SRC,
  input  logic       STALL,
  input  logic       INTR,
  input  logic       MIE,
  output logic [2:0] PC_SEL,
  output logic       PC_WRITE,
  output logic       FLUSH_IF_ID,
  output logic       FLUSH_ID_EX,
  output logic       INT_TAKEN,
  output logic       IN_ISR
`ifdef OTTER_REDIRECT_STATS_EN
  , output logic [15:0] REDIR_CNT
  , output logic [15:0] INT_CNT
`endif
);

  pc_state_t  state_q, state_d;
  logic       pend_q, pend_d;
  logic       in_isr_q, in_isr_d;
  logic       redirect, pend_set;
  logic [2:0] pc_sel;
  logic       pc_write, flush, int_taken;

  assign redirect = ((state_q == ST_RUN) || (state_q == ST_INT_WAIT)) &&
                    EX_VALID && (EX_PC_SRC != PCSEL_SEQ) && !STALL;
  // INT_ENTER counts as in-handler so a held INTR cannot re-arm before IN_ISR rises.
  assign pend_set = INTR && MIE && !in_isr_q && (state_q != ST_INT_ENTER);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | pend_set;
    in_isr_d  = in_isr_q;
    pc_sel    = PCSEL_SEQ;
    pc_write  = !STALL;
    flush     = 1'b0;
    int_taken = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect)    state_d = ST_SHADOW;
        else if (pend_q) state_d = ST_INT_WAIT;
      end
      ST_INT_WAIT: begin
        if (redirect) state_d = ST_SHADOW;
        else if (!STALL) begin
          state_d = ST_INT_ENTER;
          pend_d  = 1'b0;
        end
      end
      ST_INT_ENTER: begin
        pc_sel    = PCSEL_INTR;
        pc_write  = 1'b1;
        flush     = 1'b1;
        int_taken = 1'b1;
        in_isr_d  = 1'b1;
        state_d   = ST_SHADOW;
      end
      ST_SHADOW: state_d = pend_q ? ST_INT_WAIT : ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    if (redirect) begin
      pc_sel   = EX_PC_SRC;
      pc_write = 1'b1;
      flush    = 1'b1;
      if (EX_PC_SRC == PCSEL_MRET) in_isr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_RUN;
      pend_q   <= 1'b0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      in_isr_q <= in_isr_d;
    end
  end

  // Outputs are partly combinational, so reset must mask them directly.
  assign PC_SEL      = RST_N ? pc_sel : PCSEL_SEQ;
  assign PC_WRITE    = RST_N & pc_write;
  assign FLUSH_IF_ID = RST_N & flush;
  assign FLUSH_ID_EX = RST_N & flush;
  assign INT_TAKEN   = RST_N & int_taken;
  assign IN_ISR      = in_isr_q;

`ifdef OTTER_REDIRECT_STATS_EN
  otter_sat_counter #(.WIDTH(16)) u_redir_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc_i (redirect),
    .cnt_o (REDIR_CNT)
  );

  otter_sat_counter #(.WIDTH(16)) u_int_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc_i (int_taken),
    .cnt_o (INT_CNT)
  );
`endif

endmodule

// File: tb/tb_otter_pc_redirect_ctrl.sv
// Scoreboard bench for otter_pc_redirect_ctrl: expected outputs queued at drive time, compared at negedge.
module tb_otter_pc_redirect_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EX_VALID = 1'b0;
  logic [2:0] EX_PC_SRC = 3'b000;
  logic       STALL = 1'b0;
  logic       INTR = 1'b0;
  logic       MIE = 1'b0;
  logic [2:0] PC_SEL;
  logic       PC_WRITE, FLUSH_IF_ID, FLUSH_ID_EX, INT_TAKEN, IN_ISR;
`ifdef OTTER_REDIRECT_STATS_EN
  logic [15:0] REDIR_CNT, INT_CNT;
  int unsigned m_redir = 0, m_ints = 0;
`endif

  otter_pc_redirect_ctrl dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EX_VALID    (EX_VALID),
    .EX_PC_SRC   (EX_PC_SRC),
    .STALL       (STALL),
    .INTR        (INTR),
    .MIE         (MIE),
    .PC_SEL      (PC_SEL),
    .PC_WRITE    (PC_WRITE),
    .FLUSH_IF_ID (FLUSH_IF_ID),
    .FLUSH_ID_EX (FLUSH_ID_EX),
    .INT_TAKEN   (INT_TAKEN),
    .IN_ISR      (IN_ISR)
`ifdef OTTER_REDIRECT_STATS_EN
    , .REDIR_CNT (REDIR_CNT)
    , .INT_CNT   (INT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] sel;
    logic       wr;
    logic       fif;
    logic       fex;
    logic       tk;
    logic       isr;
  } exp_t;

  typedef enum logic [1:0] {M_RUN, M_SHADOW, M_WAIT, M_ENTER} mst_t;

  exp_t exp_q[$];
  mst_t m_st = M_RUN;
  logic m_pend = 1'b0;
  logic m_isr = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   taken_seen = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model predicts this cycle's outputs then advances.
  task automatic cyc(input logic rst, input logic ev, input logic [2:0] src,
                     input logic st, input logic intr, input logic mie);
    exp_t e;
    logic redir;
    mst_t nxt;
    logic np;
    @(posedge CLK); #1;
    RST_N = rst; EX_VALID = ev; EX_PC_SRC = src; STALL = st; INTR = intr; MIE = mie;
    e = '0;
    if (!rst) begin
      m_st = M_RUN; m_pend = 1'b0; m_isr = 1'b0;
`ifdef OTTER_REDIRECT_STATS_EN
      m_redir = 0; m_ints = 0;
`endif
    end else begin
      redir = (m_st == M_RUN || m_st == M_WAIT) && ev && (src != 3'b000) && !st;
      e.isr = m_isr;
      if (m_st == M_ENTER) begin
        e.sel = 3'b100; e.wr = 1'b1; e.fif = 1'b1; e.fex = 1'b1; e.tk = 1'b1;
      end else if (redir) begin
        e.sel = src; e.wr = 1'b1; e.fif = 1'b1; e.fex = 1'b1;
      end else begin
        e.wr = !st;
      end
      np  = m_pend | (intr && mie && !m_isr && m_st != M_ENTER);
      nxt = m_st;
      if (m_st == M_ENTER) begin
        nxt = M_SHADOW; m_isr = 1'b1;
      end else if (m_st == M_SHADOW) begin
        nxt = m_pend ? M_WAIT : M_RUN;
      end else if (redir) begin
        nxt = M_SHADOW;
        if (src == 3'b101) m_isr = 1'b0;
      end else if (m_st == M_RUN && m_pend) begin
        nxt = M_WAIT;
      end else if (m_st == M_WAIT && !st) begin
        nxt = M_ENTER; np = 1'b0;
      end
`ifdef OTTER_REDIRECT_STATS_EN
      if (redir && m_redir < 65535) m_redir++;
      if (e.tk && m_ints < 65535) m_ints++;
`endif
      m_st = nxt; m_pend = np;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic intr);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'b000, 1'b0, intr, 1'b1);
  endtask

  task automatic settle();
    @(negedge CLK); #1;
  endtask

  always @(negedge CLK) begin : scoreboard
    exp_t e;
    if (INT_TAKEN === 1'b1) taken_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_sel",      16'(PC_SEL),      16'(e.sel));
      chk("pc_write",    16'(PC_WRITE),    16'(e.wr));
      chk("flush_if_id", 16'(FLUSH_IF_ID), 16'(e.fif));
      chk("flush_id_ex", 16'(FLUSH_ID_EX), 16'(e.fex));
      chk("int_taken",   16'(INT_TAKEN),   16'(e.tk));
      chk("in_isr",      16'(IN_ISR),      16'(e.isr));
    end
  end

  initial begin
    // reset held with active inputs: all outputs must stay 0
    cyc(1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);           // stalled RUN: no PC write
    cyc(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1);           // stalled branch: no redirect
    // branch redirect, then shadow ignores a JAL
    cyc(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1);           // JALR right after shadow
    idle(2, 1'b0);
    // interrupt from idle, INTR held: exactly one entry
    idle(9, 1'b1);
    settle();
    chk("taken_idle", 16'(taken_seen), 16'd1);
    chk("isr_held", 16'(IN_ISR), 16'd1);
    // mret leaves the handler; still-held INTR is accepted again
    cyc(1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1);
    idle(7, 1'b1);
    settle();
    chk("taken_after_mret", 16'(taken_seen), 16'd2);
    cyc(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    // INTR coincident with JAL: JAL first, entry three cycles later
    cyc(1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    settle();
    chk("taken_after_jal", 16'(taken_seen), 16'd3);
    idle(2, 1'b0);
    cyc(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    // one-cycle INTR pulse, then 4 stall cycles in INT_WAIT
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    settle();
    chk("taken_during_stall", 16'(taken_seen), 16'd3);
    idle(4, 1'b0);
    settle();
    chk("taken_after_stall", 16'(taken_seen), 16'd4);
    cyc(1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    // interrupt masked by MIE=0
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    // reset pulse mid-INT_WAIT cancels the pending entry
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b0);
    // reset pulse mid-SHADOW
    cyc(1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    settle();
    chk("taken_total", 16'(taken_seen), 16'd4);
`ifdef OTTER_REDIRECT_STATS_EN
    chk("redir_cnt", REDIR_CNT, 16'(m_redir));
    chk("int_cnt", INT_CNT, 16'(m_ints));
    for (int i = 0; i < 65540; i++) begin
      cyc(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    end
    settle();
    chk("redir_cnt_sat", REDIR_CNT, 16'hFFFF);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
